// File: rtl/counter_pkg.sv
// Shared definitions for the counter command sequencer: opcodes, FSM state
// encodings and the default counter width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Bit 0 is set in every non-idle state, so busy/ready come straight off one flop.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b11
  } state_t;

endpackage

// File: rtl/counter_shadow.sv
// Shadow copy of the downstream up/down counter; flags any cycle where the
// real counter output disagrees with the prediction.
module counter_shadow
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             up_down,
  input  logic [WIDTH-1:0] count_in,
  output logic             mismatch
);

  logic [WIDTH-1:0] pred;

  function automatic logic [WIDTH-1:0] next_count(
    input logic [WIDTH-1:0] cur,
    input logic             ld,
    input logic [WIDTH-1:0] d,
    input logic             up
  );
    if (ld) begin
      return d;
    end else if (up) begin
      return cur + WIDTH'(1);
    end else begin
      return cur - WIDTH'(1);
    end
  endfunction

  // pred follows the same inputs on the same edge as the real counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred     <= '0;
      mismatch <= 1'b0;
    end else begin
      pred <= next_count(pred, load, din, up_down);
      if (count_in != pred) begin
        mismatch <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/counter_seq.sv
// Command sequencer driving a loadable up/down counter with cycle-exact
// LOAD / UP / DOWN commands, plus a shadow check of the counter output.
module counter_seq
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             load,
  output logic [WIDTH-1:0] din,
  output logic             up_down,
  input  logic [WIDTH-1:0] count_in,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic             bad_op
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  logic [LEN_W-1:0] remaining;

  assign busy      = state[0];
  assign cmd_ready = ~state[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      remaining <= '0;
      load      <= 1'b0;
      din       <= '0;
      up_down   <= 1'b0;
      done      <= 1'b0;
      bad_op    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            unique case (cmd_op)
              OP_LOAD: begin
                load  <= 1'b1;
                din   <= cmd_data;
                state <= S_LOAD;
              end
              OP_UP, OP_DOWN: begin
                // zero-length runs complete at once and keep the old direction
                if (cmd_len != '0) begin
                  up_down   <= (cmd_op == OP_UP);
                  remaining <= cmd_len;
                  state     <= S_RUN;
                end else begin
                  done <= 1'b1;
                end
              end
              default: begin
                done   <= 1'b1;
                bad_op <= 1'b1;
              end
            endcase
          end
        end
        S_LOAD: begin
          load  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        S_RUN: begin
          remaining <= remaining - LEN_ONE;
          if (remaining == LEN_ONE) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  counter_shadow #(
    .WIDTH (WIDTH)
  ) u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .din      (din),
    .up_down  (up_down),
    .count_in (count_in),
    .mismatch (mismatch)
  );

`ifndef SYNTHESIS
  a_load_single : assert property (@(posedge clk) disable iff (!rst_n) load |=> !load);
  a_run_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
                                   (state == S_RUN) |-> (remaining != '0));
`endif

endmodule

// File: tb/tb_counter_seq.sv
// Bench for counter_seq: drives the sequencer into a behavioural up/down
// counter and compares against a transaction-level reference.
module tb_counter_seq;
  import counter_pkg::*;

  localparam int WIDTH = 4;
  localparam int LEN_W = 8;

  logic             clk;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [LEN_W-1:0] cmd_len;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             up_down;
  logic [WIDTH-1:0] count_in;
  logic             busy;
  logic             done;
  logic             mismatch;
  logic             bad_op;

  logic [WIDTH-1:0] cnt;
  logic             force_en;
  logic [WIDTH-1:0] force_val;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] ref_cnt;
  logic       ref_ud;
  logic       ref_bad;

  counter_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .cmd_len   (cmd_len),
    .load      (load),
    .din       (din),
    .up_down   (up_down),
    .count_in  (count_in),
    .busy      (busy),
    .done      (done),
    .mismatch  (mismatch),
    .bad_op    (bad_op)
  );

  // downstream counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (load)    cnt <= din;
    else if (up_down) cnt <= cnt + 4'd1;
    else              cnt <= cnt - 4'd1;
  end

  assign count_in = force_en ? force_val : cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected summary");
    $fatal(1);
  end

  function automatic logic [3:0] step(input logic [3:0] v, input logic up);
    int t;
    t = up ? (int'(v) + 1) % 16 : (int'(v) + 15) % 16;
    return 4'(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_load"},     load, 0);
    check({tag, "_din"},      din, 0);
    check({tag, "_up_down"},  up_down, 0);
    check({tag, "_done"},     done, 0);
    check({tag, "_mismatch"}, mismatch, 0);
    check({tag, "_bad_op"},   bad_op, 0);
    check({tag, "_busy"},     busy, 0);
    check({tag, "_ready"},    cmd_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      ref_cnt = step(ref_cnt, ref_ud);
      @(negedge clk);
      check("idle_count", count_in, ref_cnt);
    end
  endtask

  // Issue one command from a negedge with the DUT idle; returns at a negedge
  // one cycle after done with the DUT idle again.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] data, input logic [7:0] len,
                         output int lat, output int busy_c, output int load_c,
                         output logic [3:0] done_cnt);
    bit seen;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_len   = len;
    @(posedge clk);
    ref_cnt = step(ref_cnt, ref_ud);
    if ((op == OP_UP || op == OP_DOWN) && len != 0) ref_ud = (op == OP_UP);
    if (op == OP_RSVD) ref_bad = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0; busy_c = 0; load_c = 0; done_cnt = '0; seen = 0;
    for (int c = 0; c < 300; c++) begin
      check("run_count", count_in, ref_cnt);
      check("run_ready", cmd_ready, !busy);
      if (busy) busy_c++;
      if (load) begin
        load_c++;
        check("run_din", din, data);
      end
      if (done) begin
        lat = c; done_cnt = count_in; seen = 1;
        break;
      end
      @(posedge clk);
      ref_cnt = (op == OP_LOAD && c == 0) ? data : step(ref_cnt, ref_ud);
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 0, 1);
    check("run_up_down", up_down, ref_ud);
    check("run_bad_op", bad_op, ref_bad);
    check("run_mismatch", mismatch, 0);
    @(posedge clk);
    ref_cnt = step(ref_cnt, ref_ud);
    @(negedge clk);
    check("done_single_pulse", done, 0);
    check("after_count", count_in, ref_cnt);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [3:0] data;
    logic [7:0] len;
    int         lat;
    int         busy_c;
    int         load_c;
    logic       ud;
    logic       bad;
    logic [3:0] cnt;
  } tv_t;

  tv_t tv[9];

  initial begin
    int lat, busy_c, load_c, first_load, done_at;
    logic [3:0] dcnt;

    tv[0] = '{OP_LOAD, 4'b1011, 8'd0, 1, 1, 1, 1'b0, 1'b0, 4'b1011};
    tv[1] = '{OP_UP,   4'b0000, 8'd5, 5, 5, 0, 1'b1, 1'b0, 4'b1110};
    tv[2] = '{OP_LOAD, 4'b0001, 8'd0, 1, 1, 1, 1'b1, 1'b0, 4'b0001};
    tv[3] = '{OP_DOWN, 4'b0000, 8'd3, 3, 3, 0, 1'b0, 1'b0, 4'b0000};
    tv[4] = '{OP_UP,   4'b0000, 8'd0, 0, 0, 0, 1'b0, 1'b0, 4'b1110};
    tv[5] = '{OP_RSVD, 4'b1010, 8'd7, 0, 0, 0, 1'b0, 1'b1, 4'b1100};
    tv[6] = '{OP_UP,   4'b0000, 8'd6, 6, 6, 0, 1'b1, 1'b1, 4'b0000};
    tv[7] = '{OP_DOWN, 4'b0000, 8'd2, 2, 2, 0, 1'b0, 1'b1, 4'b0000};
    tv[8] = '{OP_UP,   4'b0000, 8'd0, 0, 0, 0, 1'b0, 1'b1, 4'b1110};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_len = '0;
    force_en = 1'b0; force_val = '0;
    ref_cnt = '0; ref_ud = 1'b0; ref_bad = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 9; i++) begin
      run_cmd(tv[i].op, tv[i].data, tv[i].len, lat, busy_c, load_c, dcnt);
      check("tv_latency", lat, tv[i].lat);
      check("tv_busy_cycles", busy_c, tv[i].busy_c);
      check("tv_load_cycles", load_c, tv[i].load_c);
      check("tv_done_count", dcnt, tv[i].cnt);
      check("tv_up_down", up_down, tv[i].ud);
      check("tv_bad_op", bad_op, tv[i].bad);
    end

    // random commands against the reference
    for (int i = 0; i < 60; i++) begin
      logic [1:0] op;
      logic [3:0] data;
      logic [7:0] len;
      int e_lat;
      op   = 2'($urandom_range(0, 3));
      data = 4'($urandom);
      len  = 8'($urandom_range(0, 9));
      idle($urandom_range(0, 3));
      e_lat = (op == OP_LOAD) ? 1 : (((op == OP_UP || op == OP_DOWN) && len != 0) ? int'(len) : 0);
      run_cmd(op, data, len, lat, busy_c, load_c, dcnt);
      check("rnd_latency", lat, e_lat);
      check("rnd_busy_cycles", busy_c, e_lat);
      check("rnd_load_cycles", load_c, (op == OP_LOAD) ? 1 : 0);
      if (op == OP_LOAD) check("rnd_load_value", dcnt, data);
    end

    // a command presented while busy waits until the run completes
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = '0; cmd_len = 8'd4;
    @(posedge clk);
    @(negedge clk);
    cmd_op = OP_LOAD; cmd_data = 4'b0110; cmd_len = '0;
    first_load = -1; done_at = -1;
    for (int c = 0; c < 20; c++) begin
      if (done && done_at < 0) done_at = c;
      if (load) begin
        first_load = c;
        break;
      end
      check("held_ready_vs_busy", cmd_ready, !busy);
      @(posedge clk);
      @(negedge clk);
    end
    check("held_run_done_at", done_at, 4);
    check("held_load_at", first_load, 5);
    check("held_din", din, 4'b0110);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("held_load_count", count_in, 4'b0110);
    check("held_load_done", done, 1);
    ref_cnt = 4'b0110; ref_ud = 1'b1;
    idle(1);

    // corrupted counter output for one cycle
    for (int i = 0; i < 40 && count_in != 4'b0011; i++) idle(1);
    check("pred_reach_0011", count_in, 4'b0011);
    check("mismatch_before_force", mismatch, 0);
    force_val = 4'b0111; force_en = 1'b1;
    @(posedge clk);
    ref_cnt = step(ref_cnt, ref_ud);
    @(negedge clk);
    force_en = 1'b0;
    check("mismatch_rise", mismatch, 1);
    idle(3);
    check("mismatch_sticky", mismatch, 1);

    // reset in the third cycle of UP len 10
    cmd_valid = 1'b1; cmd_op = OP_UP; cmd_data = '0; cmd_len = 8'd10;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midrun_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrun_reset");
    repeat (2) begin
      @(negedge clk);
      check("reset_no_done", done, 0);
    end
    rst_n = 1'b1;
    ref_cnt = '0; ref_ud = 1'b0; ref_bad = 1'b0;
    run_cmd(OP_LOAD, 4'b0101, 8'd0, lat, busy_c, load_c, dcnt);
    check("post_reset_latency", lat, 1);
    check("post_reset_load_value", dcnt, 4'b0101);
    check("post_reset_mismatch", mismatch, 0);
    check("post_reset_bad_op", bad_op, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
